// File: rtl/rr_mutex_arb_if.sv
// Request/grant bundle between requesters (master) and the mutex arbiter (slave).
// Carries the monitoring outputs alongside the one-hot grant.
interface rr_mutex_arb_if #(
  parameter int WD   = 4,
  parameter int CNTW = 8
);
  localparam int IDW = (WD > 1) ? $clog2(WD) : 1;

  logic [WD-1:0]   req;
  logic [WD-1:0]   gnt;
  logic [IDW-1:0]  gnt_id;
  logic            busy;
  logic [CNTW-1:0] hold_cnt;

  modport master (output req, input gnt, gnt_id, busy, hold_cnt);
  modport slave  (input req, output gnt, gnt_id, busy, hold_cnt);
endinterface

// File: rtl/rr_mutex_arb.sv
// M-to-1 mutex arbiter: grant held while its request stays high, direct handover on release,
// round-robin or fixed-priority selection, encoded owner index and saturating hold counter.
module rr_mutex_arb #(
  parameter int WD   = 4,
  parameter int MODE = 0,
  parameter int CNTW = 8
) (
  input logic              clk,
  input logic              rst_n,
  rr_mutex_arb_if.slave    bus
);
  localparam int              IDW     = (WD > 1) ? $clog2(WD) : 1;
  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [WD-1:0]   ONE_HOT = WD'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state;
  logic [IDW-1:0] last;
  logic [WD-1:0]  cand;
  logic           owner_req;
  logic           any_cand;
  logic [IDW-1:0] win;

  // The owner's own line is masked so a release can only hand over to someone else.
  assign cand      = bus.req & ~bus.gnt;
  assign owner_req = |(bus.req & bus.gnt);
  assign any_cand  = |cand;
  assign bus.busy  = (state == GRANT);

  generate
    if (MODE == 1) begin : g_fixed
      always_comb begin
        // NOTE: default first so every path assigns win and no latch is inferred.
        win = '0;
        for (int i = WD - 1; i >= 0; i--) begin
          if (cand[i]) win = IDW'(i);
        end
      end
    end else begin : g_rr
      always_comb begin
        int  idx;
        logic found;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= WD; i++) begin
          idx = (int'(last) + i) % WD;
          if (!found && cand[idx]) begin
            found = 1'b1;
            win   = IDW'(idx);
          end
        end
      end
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bus.gnt      <= '0;
      bus.gnt_id   <= '0;
      bus.hold_cnt <= '0;
      last         <= IDW'(WD - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_cand) begin
            state        <= GRANT;
            bus.gnt      <= ONE_HOT << win;
            bus.gnt_id   <= win;
            bus.hold_cnt <= CNTW'(1);
            last         <= win;
          end
        end
        GRANT: begin
          if (owner_req) begin
            if (bus.hold_cnt != CNT_MAX) bus.hold_cnt <= bus.hold_cnt + CNTW'(1);
          end else if (any_cand) begin
            bus.gnt      <= ONE_HOT << win;
            bus.gnt_id   <= win;
            bus.hold_cnt <= CNTW'(1);
            last         <= win;
          end else begin
            state        <= IDLE;
            bus.gnt      <= '0;
            bus.hold_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/rr_mutex_arb.md
# rr_mutex_arb

Clocked, parametrised M-to-1 mutual-exclusion arbiter for the synchronous side of the SDM NoC: network interfaces, test harnesses and clocked router wrappers. It keeps the mutex handshake: a grant is held for as long as its request stays high and dropped only when the request is withdrawn. It adds round-robin fairness or fixed-priority selection, direct handover between requesters, an encoded grant index and a saturating hold-time counter for performance monitoring.

## Interface
- WD, 4: number of request inputs, ≥1.
- MODE, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- CNTW, 8: width of the hold-time counter, ≥1.
- IDW, derived: max(1, clog2(WD)); not overridden.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- req  in  WD  request lines. A requester raises its line and keeps it high until it has finished using the resource.
- gnt  out  WD  registered one-hot grant, or all zero.
- gnt_id  out  IDW  index of the current owner; valid only while busy=1.
- busy  out  1  high while any gnt bit is high.
- hold_cnt  out  CNTW  cycles the current owner has held its grant; saturates at all-ones.

## Operation
- State: owner register (gnt/gnt_id/busy), round-robin pointer `last` (IDW bits), hold counter.
- Reset (rst_n=0, takes effect immediately): gnt=0, gnt_id=0, busy=0, hold_cnt=0, last=WD-1. With last=WD-1, index 0 has highest priority after reset in both modes.
- IDLE (busy=0), at each edge:
  - if req≠0, grant the winner: gnt=onehot(w), gnt_id=w, busy=1, hold_cnt=1, last=w;
  - otherwise stay idle.
- GRANT (busy=1, owner o):
  - if req[o]=1 at the edge: hold the grant and increment hold_cnt, saturating at 2^CNTW-1.
  - if req[o]=0 and no other request is high: gnt=0, busy=0, hold_cnt=0; gnt_id and last keep their values.
  - if req[o]=0 and another request is high: hand over directly in the same edge. gnt[o] falls and gnt[w] rises together, with hold_cnt=1 and last=w.
- Winner selection, combinational, over req with req[o] treated as 0 during a release:
  - MODE=0: the first set bit scanning last+1, last+2, … modulo WD.
  - MODE=1: the lowest set index.
- A non-owner request that rises and falls without being granted has no effect. The arbiter never issues a spurious grant.
- Exclusivity is unconditional: at most one gnt bit is high at any time, including the handover edge.
- WD=1: gnt[0] follows req[0] with one-cycle delay, and gnt_id=0.
- Requesters must not re-raise req until they have seen their gnt low (4-phase). If a re-raise occurs earlier, it is treated as a new request and arbitrated normally.

## Timing
- Grant latency: a req rising before edge k, with the arbiter idle, gives gnt high after edge k (1 cycle).
- Release latency: req[o] falling before edge k gives gnt[o] low after edge k.
- Handover: the next owner's gnt rises on the same edge that the old owner's gnt falls; there is no idle cycle.
- Outputs are registered only, with no combinational path from req to any output.
- hold_cnt reads 1 in the first granted cycle and equals the number of granted cycles so far, until saturation.

## Test plan
- Reset, single request: WD=4, MODE=0; req=0001 held for 5 cycles, then dropped.
  - Required: gnt=0001 one cycle later, gnt_id=0, hold_cnt=1..5.
  - After the drop, gnt=0 and busy=0 on the next edge.
- Round-robin fairness: all four requesters continuously re-request, each releasing after 2 cycles.
  - Required: grant order 0,1,2,3,0,…, with no idle cycle between owners and exactly one gnt bit high on every cycle.
- Fixed priority: MODE=1; req=1010, then req[1] dropped after 3 cycles while req[3] stays high.
  - Required: gnt=0010 first, then a direct handover to gnt=1000 with hold_cnt restarting at 1.
- Saturation and withdraw: CNTW=3, owner holds for 12 cycles.
  - Required: hold_cnt reaches 7 and stays at 7.
  - Concurrently, a non-owner pulses req for 2 cycles; required: no grant to it and gnt unchanged.
- Asynchronous reset mid-grant: rst_n pulled low between edges while gnt=0100.
  - Required: all outputs 0 immediately.
  - After release with req=1111 held, the first grant goes to index 0.
